// File: rtl/counter_timer_pkg.sv
// Shared constants and types for the Wishbone counter/timer peripheral:
// register offsets, CONFIG bit positions and the CONFIG register layout.
package counter_timer_pkg;

    localparam logic [3:0] CFG_OFS = 4'h0;
    localparam logic [3:0] VAL_OFS = 4'h4;
    localparam logic [3:0] DAT_OFS = 4'h8;
    localparam logic [3:0] PRE_OFS = 4'hC;

    localparam int EN_B      = 0;
    localparam int ONESHOT_B = 1;
    localparam int UP_B      = 2;
    localparam int IRQEN_B   = 3;

    // Field order matches the CONFIG bit indices above (bit3 first).
    typedef struct packed {
        logic irq_en;
        logic up;
        logic oneshot;
        logic en;
    } cfg_t;

    // Replace only the bytes whose lane select is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) merged[8*b +: 8] = new_v[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/counter_timer_wb_if.sv
// Wishbone classic slave bus bundle for the counter/timer peripheral.
interface counter_timer_wb_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/counter_timer_core.sv
// Counting engine: prescaler, up/down count datapath, terminal-event detect
// and the registered single-cycle interrupt pulse.
module counter_timer_core
    import counter_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  cfg_t                  cfg,
    input  logic                  cfg_we,
    input  logic [31:0]           data,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  val_we,
    input  logic [31:0]           val_wdata,
    output logic [31:0]           value,
    output logic                  en_clr,
    output logic                  irq
);

    logic [PRESCALE_W-1:0] pcnt;
    logic                  tick;
    logic                  at_term;
    logic                  term;

    assign tick    = cfg.en && (pcnt == prescale);
    assign at_term = cfg.up ? (value == data) : (value == 32'd0);
    // A bus write to VALUE discards a coincident tick, terminal event included.
    assign term    = tick && !val_we && at_term;
    assign en_clr  = term && cfg.oneshot;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt  <= '0;
            value <= '0;
            irq   <= 1'b0;
        end else begin
            irq <= term && cfg.irq_en;

            // Any CONFIG write restarts the prescale period from zero.
            if (cfg_we || !cfg.en || tick) pcnt <= '0;
            else                           pcnt <= pcnt + 1'b1;

            if (val_we) begin
                value <= val_wdata;
            end else if (tick) begin
                if (!at_term)          value <= cfg.up ? value + 32'd1 : value - 32'd1;
                else if (!cfg.oneshot) value <= cfg.up ? 32'd0 : data;
            end
        end
    end

endmodule

// File: rtl/counter_timer_wb.sv
// Wishbone-attached 32-bit counter/timer: address decode, byte-lane register
// file, single-cycle ack generation and registered read mux around the core.
module counter_timer_wb
    import counter_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h2000_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    counter_timer_wb_if.slave  wb,
    output logic               irq_o
);

    // Handshake: a decoded cyc&stb while ack is low is accepted on that edge;
    // ack is high for exactly the next cycle, reads return the pre-edge value
    // with ack, writes land on the accepting edge, and the cycle after ack
    // never accepts, so back-to-back strobes complete every two cycles.
    cfg_t                  cfg_q;
    logic [31:0]           data_q;
    logic [PRESCALE_W-1:0] pre_q;
    logic                  ack_q;
    logic [31:0]           rdat_q;

    logic                  hit;
    logic                  acc;
    logic                  wr;
    logic                  rd;
    logic [3:0]            ofs;
    logic                  cfg_we;
    logic                  val_we;
    logic                  dat_we;
    logic                  pre_we;
    logic [31:0]           value;
    logic                  en_clr;
    logic [31:0]           rdata;

    assign hit = wb.wb_cyc_i && wb.wb_stb_i && (wb.wb_adr_i[31:4] == BASE_ADR[31:4]);
    assign acc = hit && !ack_q;
    assign wr  = acc && wb.wb_we_i;
    assign rd  = acc && !wb.wb_we_i;
    assign ofs = wb.wb_adr_i[3:0];

    // CONFIG lives entirely in byte lane 0.
    assign cfg_we = wr && (ofs == CFG_OFS) && wb.wb_sel_i[0];
    assign val_we = wr && (ofs == VAL_OFS);
    assign dat_we = wr && (ofs == DAT_OFS);
    assign pre_we = wr && (ofs == PRE_OFS);

    counter_timer_core #(
        .PRESCALE_W (PRESCALE_W)
    ) u_core (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .cfg       (cfg_q),
        .cfg_we    (cfg_we),
        .data      (data_q),
        .prescale  (pre_q),
        .val_we    (val_we),
        .val_wdata (lane_merge(value, wb.wb_dat_i, wb.wb_sel_i)),
        .value     (value),
        .en_clr    (en_clr),
        .irq       (irq_o)
    );

    always_comb begin
        rdata = 32'd0;
        case (ofs)
            CFG_OFS: rdata = {28'd0, cfg_q};
            VAL_OFS: rdata = value;
            DAT_OFS: rdata = data_q;
            PRE_OFS: rdata = 32'(pre_q);
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cfg_q  <= '0;
            data_q <= '0;
            pre_q  <= '0;
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            ack_q  <= acc;
            rdat_q <= rd ? rdata : 32'd0;

            // Firmware writes to CONFIG take priority over the one-shot EN clear.
            if (cfg_we)      cfg_q    <= cfg_t'(wb.wb_dat_i[3:0]);
            else if (en_clr) cfg_q.en <= 1'b0;

            if (dat_we) data_q <= lane_merge(data_q, wb.wb_dat_i, wb.wb_sel_i);
            if (pre_we) pre_q  <= PRESCALE_W'(lane_merge(32'(pre_q), wb.wb_dat_i, wb.wb_sel_i));
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdat_q;

endmodule

// File: tb/tb_counter_timer_wb.sv
// Self-checking bench for counter_timer_wb: directed scenarios from the test
// plan plus randomized traffic, all judged against a cycle-level reference model.
module tb_counter_timer_wb;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    logic chk_on = 1'b0;

    counter_timer_wb_if bus();

    counter_timer_wb #(
        .BASE_ADR   (BASE),
        .PRESCALE_W (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [3:0]  m_cfg;
    logic [31:0] m_val;
    logic [31:0] m_dat;
    logic [15:0] m_pre;
    int unsigned m_age;
    logic        m_ack;
    logic        m_irq;
    logic        m_rd;
    logic [31:0] m_rdata;

    logic        mh, ma, mw, mtick, mterm, mcfgw;
    logic [3:0]  mofs, ncfg;
    logic [31:0] nval;

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] o);
        case (o)
            4'h0:    return {28'd0, m_cfg};
            4'h4:    return m_val;
            4'h8:    return m_dat;
            4'hC:    return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cfg = '0; m_val = '0; m_dat = '0; m_pre = '0; m_age = 0;
            m_ack = 0; m_irq = 0; m_rd = 0; m_rdata = '0;
        end else begin
            mh    = bus.wb_cyc_i && bus.wb_stb_i && (bus.wb_adr_i[31:4] == BASE[31:4]);
            ma    = mh && !m_ack;
            mw    = ma && bus.wb_we_i;
            mofs  = bus.wb_adr_i[3:0];
            m_rd  = ma && !bus.wb_we_i;
            m_rdata = model_read(mofs);
            // Ticks fall every PRESCALE+1 cycles, counted from the enabling write.
            mtick = m_cfg[0] && ((m_age % (32'(m_pre) + 32'd1)) == 32'(m_pre));
            mcfgw = mw && (mofs == 4'h0) && bus.wb_sel_i[0];
            mterm = 1'b0;
            nval  = m_val;
            ncfg  = m_cfg;
            if (mw && mofs == 4'h4) begin
                nval = bytes_merge(m_val, bus.wb_dat_i, bus.wb_sel_i);
            end else if (mtick) begin
                if (m_cfg[2]) begin
                    if (m_val == m_dat) begin
                        mterm = 1'b1;
                        nval  = m_cfg[1] ? m_val : 32'd0;
                    end else nval = m_val + 32'd1;
                end else begin
                    if (m_val == 32'd0) begin
                        mterm = 1'b1;
                        nval  = m_cfg[1] ? 32'd0 : m_dat;
                    end else nval = m_val - 32'd1;
                end
                if (mterm && m_cfg[1]) ncfg[0] = 1'b0;
            end
            if (mcfgw) ncfg = bus.wb_dat_i[3:0];
            if (mcfgw || !m_cfg[0]) m_age = 0;
            else m_age++;
            if (mw && mofs == 4'h8) m_dat = bytes_merge(m_dat, bus.wb_dat_i, bus.wb_sel_i);
            if (mw && mofs == 4'hC) m_pre = bytes_merge({16'd0, m_pre}, bus.wb_dat_i, bus.wb_sel_i) & 32'hFFFF;
            m_irq = mterm && m_cfg[3];
            m_ack = ma;
            m_val = nval;
            m_cfg = ncfg;
        end
    end

    // Every-cycle scoreboard against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", {31'd0, bus.wb_ack_o}, {31'd0, m_ack});
            check("irq", {31'd0, irq}, {31'd0, m_irq});
            if (m_rd) check("rdata", bus.wb_dat_o, m_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_xfer(input logic we, input logic [3:0] ofs, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = BASE | {28'd0, ofs};
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.wb_ack_o) begin
                got   = 1'b1;
                rdata = bus.wb_dat_o;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_wr(input logic [3:0] ofs, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] d;
        wb_xfer(1'b1, ofs, dat, sel, d);
    endtask

    task automatic wb_rd(input logic [3:0] ofs, output logic [31:0] d);
        wb_xfer(1'b0, ofs, 32'd0, 4'hF, d);
    endtask

    task automatic idle_irq(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (irq) pulses++;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rv;
    int          cnt;

    initial begin
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_sel_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_on = 1'b1;

        // Reset state
        wb_rd(4'h0, rv); check("rst_cfg", rv, 32'd0);
        wb_rd(4'h4, rv); check("rst_val", rv, 32'd0);
        wb_rd(4'h8, rv); check("rst_dat", rv, 32'd0);
        wb_rd(4'hC, rv); check("rst_pre", rv, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus.wb_adr_i = BASE + 32'h10;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("unmapped_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;

        // Down, continuous, irq enabled
        wb_wr(4'h8, 32'd3);
        wb_wr(4'h4, 32'd2);
        wb_wr(4'hC, 32'd0);
        wb_wr(4'h0, 32'h9);
        idle_irq(8, cnt);
        check("down_irq_pulses", cnt, 32'd2);
        wb_wr(4'h0, 32'h0);
        wb_rd(4'h4, rv); check("down_stop_val", rv, 32'd1);

        // Up, one-shot, no irq
        wb_wr(4'h8, 32'h11);
        wb_wr(4'h4, 32'h0);
        wb_wr(4'h0, 32'h7);
        idle_irq(25, cnt);
        check("up_irq_pulses", cnt, 32'd0);
        wb_rd(4'h4, rv); check("up_hold_val", rv, 32'h11);
        wb_rd(4'h0, rv); check("up_cfg_en_clr", rv, 32'h6);

        // Prescaler = 4: first decrement five cycles after the EN write
        wb_wr(4'h0, 32'h0);
        wb_wr(4'hC, 32'd4);
        wb_wr(4'h4, 32'h0F);
        wb_wr(4'h0, 32'h1);
        wb_rd(4'h4, rv); check("pre_val_c2", rv, 32'h0F);
        wb_rd(4'h4, rv); check("pre_val_c4", rv, 32'h0F);
        wb_rd(4'h4, rv); check("pre_val_c6", rv, 32'h0E);

        // Disabled before the first tick: value frozen
        wb_wr(4'h0, 32'h0);
        wb_wr(4'h4, 32'h0F);
        wb_wr(4'h0, 32'h1);
        wb_wr(4'h0, 32'h0);
        wb_rd(4'h4, rv); check("frozen_val", rv, 32'h0F);
        idle_irq(20, cnt);
        wb_rd(4'h4, rv); check("frozen_val_late", rv, 32'h0F);

        // VALUE write lands on a tick edge: write wins
        wb_wr(4'hC, 32'd1);
        wb_wr(4'h4, 32'h100);
        wb_wr(4'h0, 32'h1);
        wb_wr(4'h4, 32'h12b4);
        wb_rd(4'h4, rv); check("collide_val", rv, 32'h12b4);
        wb_rd(4'h4, rv); check("collide_next", rv, 32'h12b3);

        // Byte lanes
        wb_wr(4'h0, 32'h0);
        wb_wr(4'h8, 32'h0);
        wb_wr(4'h8, 32'hdcba7cf3, 4'b0011);
        wb_rd(4'h8, rv); check("lane_low", rv, 32'h00007cf3);
        wb_wr(4'h8, 32'hdcba7cf3, 4'b1100);
        wb_rd(4'h8, rv); check("lane_high", rv, 32'hdcba7cf3);

        // Randomized scenarios, judged by the per-cycle model
        for (int s = 0; s < 30; s++) begin
            wb_wr(4'h0, 32'h0);
            wb_wr(4'hC, $urandom_range(0, 3));
            wb_wr(4'h8, $urandom_range(0, 20));
            wb_wr(4'h4, $urandom_range(0, 20));
            wb_wr(4'h0, {28'd0, 3'($urandom_range(0, 7)), 1'b1});
            for (int k = 0; k < 40; k++) begin
                case ($urandom_range(0, 9))
                    5, 6: wb_rd(4'($urandom_range(0, 3) * 4), rv);
                    7:    wb_wr(4'h4, $urandom_range(0, 20));
                    8:    wb_wr(4'h8, $urandom_range(0, 20));
                    9:    wb_wr(4'h0, {28'd0, 4'($urandom_range(0, 15))});
                    default: @(negedge clk);
                endcase
            end
            if (s == 15) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                wb_rd(4'h4, rv); check("midrst_val", rv, 32'd0);
                wb_rd(4'h0, rv); check("midrst_cfg", rv, 32'd0);
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_timer_wb.md
Name: counter_timer_wb

Overview:
- 32-bit programmable counter/timer peripheral on the management SoC Wishbone bus.
- Firmware programs it. Firmware then reads it back and publishes the value on the mprj_io count/check bits that the GPIO-level timer testbench monitors.
- Supports one-shot and continuous modes, up and down counting, a prescaler, and a single-cycle interrupt pulse on terminal count.
- Sits upstream of the timer testbench observation path, between the Wishbone interconnect and the CPU IRQ lines.

Parameters:
- BASE_ADR, 32'h2000_0000: Wishbone base address; block decodes adr[31:4] == BASE_ADR[31:4].
- PRESCALE_W, 16: width of the prescaler register and prescale counter.

Ports:
- wb_clk_i  in  1  single system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lanes.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_dat_o  out  32  read data.
- irq_o  out  1  terminal-count interrupt pulse.

Behaviour:
- Register map (offset from BASE_ADR):
  - 0x0 CONFIG[3:0]: bit0 EN, bit1 ONESHOT, bit2 UP, bit3 IRQ_EN.
  - 0x4 VALUE[31:0]: current count.
  - 0x8 DATA[31:0]: reload value in down mode, limit in up mode.
  - 0xC PRESCALE[PRESCALE_W-1:0].
  - Unused bits read 0. Writes honour wb_sel_i byte lanes.
- Reset: all registers 0, prescale counter 0, wb_ack_o=0, wb_dat_o=0, irq_o=0.
- Wishbone handshake:
  - A selected stb&cyc with ack low produces ack high on the next cycle, for exactly 1 cycle.
  - The following cycle never acks, so back-to-back strobes complete every 2 cycles.
  - Read data is valid with ack. Writes take effect on the ack cycle edge.
  - Unselected addresses produce no ack.
- Tick generation:
  - With EN=1, the prescale counter increments each cycle.
  - When it equals PRESCALE, tick=1 and it returns to 0. PRESCALE=0 therefore gives a tick every cycle.
  - With EN=0 the prescale counter holds at 0.
- Down mode (UP=0), on tick:
  - VALUE != 0: VALUE <= VALUE-1.
  - VALUE == 0: terminal event.
    - ONESHOT=1: VALUE stays 0 and EN is cleared.
    - ONESHOT=0: VALUE <= DATA.
- Up mode (UP=1), on tick:
  - VALUE != DATA: VALUE <= VALUE+1, wrapping modulo 2^32 if VALUE > DATA.
  - VALUE == DATA: terminal event.
    - ONESHOT=1: VALUE holds and EN is cleared.
    - ONESHOT=0: VALUE <= 0.
- irq_o is high for exactly 1 cycle, in the cycle after a terminal event, when IRQ_EN=1.
- Simultaneous events:
  - A bus write to VALUE in the same cycle as a tick wins; the tick is discarded.
  - A bus write to CONFIG wins over the hardware EN clear.
  - A write to DATA affects only subsequent reloads and compares.
- Reading VALUE returns the value before the edge on which ack rises. No shadow latch.
- Reset mid-count returns to the reset state on the next edge. No irq is emitted.
- Writing EN=1 clears the prescale counter, so the first tick occurs PRESCALE+1 cycles later.

Decomposition:
- Package counter_timer_pkg:
  - register offset constants CFG_OFS, VAL_OFS, DAT_OFS, PRE_OFS;
  - CONFIG bit index constants EN_B, ONESHOT_B, UP_B, IRQEN_B;
  - a packed struct for CONFIG.
- Sub-module counter_timer_core: prescaler, count datapath, terminal-event detect and irq pulse. It takes register write strobes and values; it outputs VALUE and the EN clear.
- counter_timer_wb holds the Wishbone decode, the byte-lane registers, the ack generation and the read mux.

Test Plan:
- Reset check: after reset, read all 4 registers -> all 0; irq_o=0; no ack for address BASE+0x10.
- Down, continuous:
  - Setup: DATA=3, VALUE=2, PRESCALE=0, CONFIG=0b1001.
  - Expected per-cycle VALUE: 2,1,0,3,2,1,0,3.
  - Expected irq_o: one 1-cycle pulse after each 0, i.e. 2 pulses in 8 ticks.
- Up, one-shot:
  - Setup: DATA=0x11, VALUE=0, CONFIG=0b0111.
  - Expected: VALUE reaches 0x11 and holds; CONFIG reads 0b0110 (EN cleared); no irq, since IRQ_EN=0.
- Prescaler:
  - Setup: PRESCALE=4, DOWN, VALUE=0x0F, EN.
  - Expected: VALUE decrements once per 5 cycles; 0x0E appears 5 cycles after the EN write.
  - Also: EN=0 then read -> VALUE frozen at the current value, e.g. 0x0F if disabled before the first tick.
- Write collision: write VALUE=0x12b4 on the same edge as a tick -> read returns 0x12b4, then 0x12b3 after one more tick.
- Byte lanes: write 0xdcba7cf3 to DATA with wb_sel_i=4'b0011 over 0 -> DATA reads 0x00007cf3; repeat with sel=4'b1100 -> 0xdcba7cf3.
